// File: rtl/uram_pipe_sdp.sv
// Simple-dual-port URAM-style memory: byte-lane arrays, valid-tagged read pipeline and a zeroing sweep.
// Define URAM_WRITE_FORWARD_EN for write-first collisions (default build is read-first).
module uram_pipe_sdp_lane #(
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [7:0]               rdata
);
    logic [7:0] mem [0:(1<<ADDRESS_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef URAM_WRITE_FORWARD_EN
    // Same-cycle hit sees this lane's incoming byte; untouched lanes keep the old byte.
    assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
    assign rdata = mem[raddr];
`endif
endmodule

module uram_pipe_sdp #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12,
    parameter int READ_LATENCY  = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ren,
    input  logic [ADDRESS_WIDTH-1:0]  raddr,
    output logic                      rvalid,
    output logic [DATA_WIDTH-1:0]     dout,
    input  logic [DATA_WIDTH/8-1:0]   wen,
    input  logic [ADDRESS_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      clear,
    output logic                      busy
);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] ccnt, ccnt_nxt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= CLEAR;
            ccnt  <= '0;
        end else begin
            state <= state_nxt;
            ccnt  <= ccnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ccnt_nxt  = ccnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    ccnt_nxt  = '0;
                end
            end
            CLEAR: begin
                ccnt_nxt = ccnt + 1'b1;
                if (&ccnt) state_nxt = IDLE;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    logic                            rd_acc;
    logic [NUM_LANES-1:0]            lane_we;
    logic [ADDRESS_WIDTH-1:0]        lane_waddr;
    logic [NUM_LANES-1:0][7:0]       lane_wdata;
    logic [NUM_LANES-1:0][7:0]       lane_rdata;

    // The sweep owns the write port; user traffic is dropped while it runs.
    assign rd_acc = ren & ~busy;

    always_comb begin
        lane_we    = wen;
        lane_waddr = waddr;
        lane_wdata = din;
        if (busy) begin
            lane_we    = '1;
            lane_waddr = ccnt;
            lane_wdata = '0;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        uram_pipe_sdp_lane #(
            .ADDRESS_WIDTH(ADDRESS_WIDTH)
        ) u_lane (
            .clock (clock),
            .we    (lane_we[i]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[i]),
            .raddr (raddr),
            .rdata (lane_rdata[i])
        );
    end

    logic [READ_LATENCY:1]                 vld_pipe;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

    // Data stages only load behind a valid bit, so the last stage holds between reads.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) dat_pipe[1] <= lane_rdata;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rvalid = vld_pipe[READ_LATENCY];
    assign dout   = dat_pipe[READ_LATENCY];
endmodule

// File: tb/tb_uram_pipe_sdp.sv
// Randomized bench for uram_pipe_sdp against a word-level memory model, plus directed literal checks.
module tb_uram_pipe_sdp;
    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int RL    = 3;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ren = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [AW-1:0] waddr = '0;
    logic [NB-1:0] wen = '0;
    logic [DW-1:0] din = '0;
    logic          rvalid;
    logic          busy;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uram_pipe_sdp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset_n(reset_n), .ren(ren), .raddr(raddr), .rvalid(rvalid),
        .dout(dout), .wen(wen), .waddr(waddr), .din(din), .clear(clear), .busy(busy)
    );

    typedef struct {
        longint        due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy = 0;
    longint        edge_n = 0;
    rd_t           pq[$];
    logic [DW-1:0] m_dout = '0;
    logic          last_rv;
    logic [DW-1:0] last_rd;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r = o;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    // One clock: advance the model on the same edge as the DUT, then compare outputs.
    task automatic step();
        logic exp_rv;
        @(posedge clock);
        edge_n++;
        if (!reset_n) begin
            m_busy = DEPTH;
            pq.delete();
            m_dout = '0;
            foreach (m_mem[a]) m_mem[a] = '0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (ren) begin
                rd_t r;
                r.due = edge_n + RL - 1;
`ifdef URAM_WRITE_FORWARD_EN
                r.data = (waddr == raddr) ? merge(m_mem[raddr], din, wen) : m_mem[raddr];
`else
                r.data = m_mem[raddr];
`endif
                pq.push_back(r);
            end
            m_mem[waddr] = merge(m_mem[waddr], din, wen);
            if (clear) begin
                m_busy = DEPTH;
                foreach (m_mem[a]) m_mem[a] = '0;
            end
        end
        exp_rv = (pq.size() > 0) && (pq[0].due == edge_n);
        if (exp_rv) begin
            m_dout = pq[0].data;
            void'(pq.pop_front());
        end
        #1;
        check("busy", DW'(busy), DW'(m_busy > 0));
        check("rvalid", DW'(rvalid), DW'(exp_rv));
        check("dout", dout, m_dout);
        last_rv = rvalid;
        last_rd = dout;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        waddr = a; din = d; wen = be;
        step();
        wen = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int n = 0;
        raddr = a; ren = 1'b1;
        step();
        ren = 1'b0;
        while (!last_rv && n < 8) begin
            step();
            n++;
        end
        if (!last_rv) check("rd_timeout", DW'(0), DW'(1));
        d = last_rd;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check(name, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        logic [DW-1:0] d;

        // Reset and automatic sweep
        step();
        step();
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_dout", dout, DW'(0));
        reset_n = 1'b1;
        count_busy("reset_sweep_len");
        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a), d);
            check("swept_zero", d, DW'(0));
        end

        // Latency and hold
        wr(AW'(5), 64'h1122334455667788, '1);
        raddr = AW'(5); ren = 1'b1;
        step();
        ren = 1'b0;
        check("lat_n0", DW'(rvalid), DW'(0));
        step();
        check("lat_n1", DW'(rvalid), DW'(0));
        step();
        check("lat_n2_valid", DW'(rvalid), DW'(1));
        check("lat_n2_data", dout, 64'h1122334455667788);
        step();
        check("hold_valid", DW'(rvalid), DW'(0));
        check("hold_data", dout, 64'h1122334455667788);

        // Byte enables
        wr(AW'(3), '1, '1);
        wr(AW'(3), 64'hAB, 8'h01);
        rd(AW'(3), d);
        check("byte_merge", d, 64'hFFFF_FFFF_FFFF_FFAB);

        // Same-cycle collision
        wr(AW'(7), 64'hA, '1);
        waddr = AW'(7); din = 64'hB; wen = '1; raddr = AW'(7); ren = 1'b1;
        step();
        wen = '0; ren = 1'b0;
        while (!last_rv) step();
`ifdef URAM_WRITE_FORWARD_EN
        check("collision", last_rd, 64'hB);
`else
        check("collision", last_rd, 64'hA);
`endif
        rd(AW'(7), d);
        check("after_collision", d, 64'hB);

        // Back-to-back reads
        ren = 1'b1; raddr = AW'(5);
        step();
        raddr = AW'(3);
        step();
        ren = 1'b0;
        step();
        check("b2b_first", dout, 64'h1122334455667788);
        step();
        check("b2b_second_valid", DW'(rvalid), DW'(1));
        check("b2b_second", dout, 64'hFFFF_FFFF_FFFF_FFAB);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            ren   = $urandom_range(0, 1);
            raddr = AW'($urandom);
            wen   = NB'($urandom);
            waddr = AW'($urandom);
            din   = {$urandom, $urandom};
            clear = ($urandom_range(0, 63) == 0);
            step();
        end
        ren = 1'b0; wen = '0; clear = 1'b0;
        while (busy) step();

        // Fill, clear with a concurrent write, traffic during the sweep
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), {$urandom, $urandom} | DW'(1), '1);
        waddr = AW'(2); din = 64'h55; wen = '1; clear = 1'b1;
        step();
        wen = '0; clear = 1'b0;
        begin
            int n = 0;
            while (busy && n < 100) begin
                n++;
                ren = $urandom_range(0, 1); raddr = AW'($urandom);
                wen = NB'($urandom); waddr = AW'($urandom); din = {$urandom, $urandom};
                clear = $urandom_range(0, 1);
                step();
            end
            check("clear_sweep_len", DW'(n), DW'(DEPTH));
        end
        ren = 1'b0; wen = '0; clear = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a), d);
            check("cleared_zero", d, DW'(0));
        end

        // Reset mid-sweep with a read in flight
        wr(AW'(1), 64'hDEAD, '1);
        ren = 1'b1; raddr = AW'(1); clear = 1'b1;
        step();
        ren = 1'b0; clear = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("reset_flush_rvalid", DW'(rvalid), DW'(0));
        count_busy("restart_sweep_len");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
